// File: rtl/prog_loader_pkg.sv
// Shared definitions for the Hack program loader: defaults, NOP encoding and FSM states.
// CHK is only reachable when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int unsigned AddrWDef = 15;
  localparam int unsigned DataWDef = 16;

  localparam logic [15:0] HACK_NOP = 16'h0000;

  typedef enum logic [2:0] {
    StRun,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StFinish,
    StError,
    StChk
  } state_e;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-pair to word assembler: high byte first, one-cycle word_valid after the low byte.
// With PROG_LOADER_CHECKSUM_EN defined it also keeps a running XOR of every data byte.
module prog_loader_word_asm
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic              clear_i,
  output logic [7:0]        csum_o,
`endif
  input  logic              hi_valid_i,
  input  logic              lo_valid_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;

  always_comb begin
    hi_d         = hi_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (hi_valid_i) begin
      hi_d = byte_i;
    end
    if (lo_valid_i) begin
      word_d       = DATA_W'({hi_q, byte_i});
      word_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear_i) begin
      csum_d = '0;
    end else if (hi_valid_i || lo_valid_i) begin
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule

// File: rtl/prog_loader.sv
// Arbitrates the Hack instruction RAM between CPU fetch and a serial program loader.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = AddrWDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Largest word count that fits between LOAD_BASE and the top of memory.
  localparam logic [31:0] MaxWords = (32'd1 << ADDR_W) - 32'(LOAD_BASE);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       len_w;

  logic              asm_clear, asm_hi, asm_lo;
  logic [DATA_W-1:0] asm_word;
  logic              asm_word_valid;

  assign len_w = {cnt_q[15:8], rx_data};

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] asm_csum;
  localparam state_e StLast = StChk;
`else
  localparam state_e StLast = StFinish;
`endif

  prog_loader_word_asm #(
    .DATA_W (DATA_W)
  ) u_word_asm (
    .clk_i        (clk),
    .rst_i        (reset),
`ifdef PROG_LOADER_CHECKSUM_EN
    .clear_i      (asm_clear),
    .csum_o       (asm_csum),
`endif
    .hi_valid_i   (asm_hi),
    .lo_valid_i   (asm_lo),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    asm_clear = 1'b0;
    asm_hi    = 1'b0;
    asm_lo    = 1'b0;

    // Address steps past each word once its write cycle has completed.
    if (asm_word_valid) begin
      addr_d = addr_q + 1'b1;
    end

    unique case (state_q)
      StRun, StError: begin
        if (start_load) begin
          state_d   = StLenHi;
          addr_d    = ADDR_W'(LOAD_BASE);
          asm_clear = 1'b1;
        end
      end
      StLenHi: begin
        if (rx_valid) begin
          cnt_d   = {rx_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (rx_valid) begin
          cnt_d = len_w;
          if (len_w == 16'd0) begin
            state_d = StLast;
          end else if ({16'h0000, len_w} > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: begin
        if (rx_valid) begin
          asm_hi  = 1'b1;
          state_d = StDatLo;
        end
      end
      StDatLo: begin
        if (rx_valid) begin
          asm_lo  = 1'b1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? StLast : StDatHi;
        end
      end
      StFinish: begin
        state_d = StRun;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk: begin
        if (rx_valid) begin
          state_d = (rx_data == asm_csum) ? StFinish : StError;
        end
      end
`endif
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      addr_q  <= ADDR_W'(LOAD_BASE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign busy      = (state_q != StRun);
  assign done      = (state_q == StFinish);
  assign err       = (state_q == StError);
  assign cpu_reset = reset | busy;
  assign cpu_instr = busy ? DATA_W'(HACK_NOP) : mem_rdata;
  assign mem_addr  = busy ? addr_q : cpu_pc;
  assign mem_wdata = asm_word;
  // A write still pending when reset arrives is dropped.
  assign mem_we    = asm_word_valid & ~reset;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; covers checksum tests when
// PROG_LOADER_CHECKSUM_EN is defined for both bench and design.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_load;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [14:0] cpu_pc;
  logic [15:0] cpu_instr;
  logic        cpu_reset;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start_load (start_load),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cpu_pc     (cpu_pc),
    .cpu_instr  (cpu_instr),
    .cpu_reset  (cpu_reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log captured mid-cycle.
  logic [14:0] wr_addr [16];
  logic [15:0] wr_data [16];
  int          wr_n   = 0;
  int          done_n = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n = wr_n + 1;
    end
    if (done) done_n = done_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    cycle();
    start_load = 1'b0;
  endtask

  logic [7:0]  prog6 [14];
  logic [15:0] exp6  [6];

  initial begin
    prog6 = '{8'h00, 8'h06, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03,
              8'hE0, 8'h90, 8'h00, 8'h00, 8'hE3, 8'h08};
    exp6  = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090, 16'h0000, 16'hE308};

    reset      = 1'b1;
    start_load = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    cpu_pc     = 15'd3;
    mem_rdata  = 16'hE090;

    // Reset and run
    cycle();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_mem_we", mem_we, 0);
    cycle();
    reset = 1'b0;
    #1;
    check("run_cpu_reset", cpu_reset, 0);
    check("run_cpu_instr", cpu_instr, 16'hE090);
    check("run_mem_addr", mem_addr, 3);
    check("run_busy", busy, 0);
    check("run_mem_we", mem_we, 0);
    check("run_err", err, 0);

    // Six-word back-to-back load
    wr_n = 0;
    done_n = 0;
    pulse_start();
    check("ld_busy", busy, 1);
    check("ld_cpu_reset", cpu_reset, 1);
    check("ld_cpu_instr_nop", cpu_instr, 16'h0000);
    for (int i = 0; i < 14; i++) send(prog6[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h66);
`endif
    check("ld_done", done, 1);
    check("ld_cpu_reset_fin", cpu_reset, 1);
    cycle();
    check("ld_cpu_reset_rel", cpu_reset, 0);
    check("ld_done_clr", done, 0);
    check("ld_wr_n", wr_n, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_n) begin
        check("ld_wr_addr", 32'(wr_addr[i]), i);
        check("ld_wr_data", 32'(wr_data[i]), 32'(exp6[i]));
      end
    end
    check("ld_done_n", done_n, 1);

    // Zero-length load
    wr_n = 0;
    done_n = 0;
    pulse_start();
    send(8'h00);
    send(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("z_done", done, 1);
    cycle();
    check("z_cpu_reset", cpu_reset, 0);
    check("z_wr_n", wr_n, 0);
    check("z_done_n", done_n, 1);

    // Oversize length
    wr_n = 0;
    pulse_start();
    send(8'h80);
    send(8'h01);
    check("big_err", err, 1);
    check("big_cpu_reset", cpu_reset, 1);
    repeat (3) cycle();
    check("big_err_sticky", err, 1);
    check("big_cpu_instr", cpu_instr, 16'h0000);
    check("big_wr_n", wr_n, 0);
    pulse_start();
    check("big_err_clr", err, 0);
    check("big_busy", busy, 1);
    send(8'h00);
    send(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("big_recover_done", done, 1);
    cycle();

    // Ignored restart, then reset mid-load with a write pending
    wr_n = 0;
    pulse_start();
    send(8'h00);
    send(8'h03);
    send(8'h00);
    send(8'h02);
    pulse_start();
    check("mid_busy", busy, 1);
    check("mid_addr_kept", mem_addr, 1);
    send(8'hEC);
    send(8'h10);
    reset = 1'b1;
    #1;
    check("mid_we_dropped", mem_we, 0);
    check("mid_rst_cpu_reset", cpu_reset, 1);
    cycle();
    reset = 1'b0;
    #1;
    check("mid_busy_clr", busy, 0);
    check("mid_cpu_reset", cpu_reset, 0);
    check("mid_mem_addr", mem_addr, 3);
    repeat (3) cycle();
    check("mid_wr_n", wr_n, 1);
    check("mid_wr_addr", 32'(wr_addr[0]), 0);
    check("mid_wr_data", 32'(wr_data[0]), 32'h0002);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum good and bad
    wr_n = 0;
    pulse_start();
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    send(8'h26);
    check("ck_done", done, 1);
    cycle();
    check("ck_cpu_reset", cpu_reset, 0);
    check("ck_wr_data", 32'(wr_data[0]), 32'h1234);
    pulse_start();
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    send(8'h27);
    check("ckbad_err", err, 1);
    check("ckbad_cpu_reset", cpu_reset, 1);
    cycle();
    check("ckbad_hold", cpu_reset, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
